fifo_write_arbiter: RTL and testbench

//   Round-robin write arbiter sharing one fifo write port between REQUESTERS producers.

---
 rtl/fifo_write_arbiter.sv | 125 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter that shares one fifo write port between REQUESTERS
//   producers. The arbiter sits directly in front of the fifo. A word is written
//   in the same cycle that its grant bit is high.
//
//   Optional feature: define FIFO_ARB_BURST_EN to let the current owner keep
//   the port for up to BURST_LEN consecutive grants. If the macro is undefined,
//   the arbiter is pure round-robin and BURST_LEN is ignored.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   ce             clock enable, shared with the fifo
//   req            per-producer data-valid
//   req_data       producer i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   grant          one-hot, combinational; bit i = producer i written this cycle
//   fifo_full      fifo full flag; while it is high, nothing is written
//   fifo_wr_en     fifo write enable, combinational
//   fifo_wr_data   fifo write data, combinational, '0 when not writing
//   last_idx       registered index of the most recent grant
module fifo_write_arbiter #(
   parameter int REQUESTERS = 4,
   parameter int DATA_WIDTH = 22,
   parameter int BURST_LEN  = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             ce,
   input  logic [REQUESTERS-1:0]            req,
   input  logic [REQUESTERS*DATA_WIDTH-1:0] req_data,
   output logic [REQUESTERS-1:0]            grant,
   input  logic                             fifo_full,
   output logic                             fifo_wr_en,
   output logic [DATA_WIDTH-1:0]            fifo_wr_data,
   output logic [$clog2(REQUESTERS)-1:0]    last_idx
);
   localparam int IDX_W = $clog2(REQUESTERS);

   logic [IDX_W-1:0] sel_rr;
   logic [IDX_W-1:0] sel;

   // Any write also advances all state. Therefore ce=0, fifo_full=1 and
   // "no request" all freeze the arbiter.
   assign fifo_wr_en = ce & ~rst & ~fifo_full & (|req);

   // Rotating scan that starts just after last_idx. last_idx itself is checked last.
   always_comb begin
      int idx;
      logic found;
      idx    = 0;
      found  = 1'b0;
      sel_rr = last_idx;
      for (int k = 1; k <= REQUESTERS; k++) begin
         idx = (int'(last_idx) + k) % REQUESTERS;
         if (!found && req[idx]) begin
            sel_rr = IDX_W'(idx);
            found  = 1'b1;
         end
      end
   end

`ifdef FIFO_ARB_BURST_EN
   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             lock_hit;

   // When a lock is held, the owner is always the most recent grantee, so
   // last_idx identifies the owner. No separate register is needed.
   assign lock_hit = (state == LOCKED) && req[last_idx];
   assign sel      = lock_hit ? last_idx : sel_rr;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (fifo_wr_en) begin
         if (lock_hit) begin
            if (cnt == CNT_W'(BURST_LEN - 1)) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end else if (BURST_LEN > 1) begin
            // A fresh round-robin grant. This covers IDLE, and it also covers a
            // locked owner that has dropped req.
            state_nxt = LOCKED;
            cnt_nxt   = CNT_W'(1);
         end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end
`else
   assign sel = sel_rr;
`endif

   always_ff @(posedge clk) begin
      if (rst)             last_idx <= IDX_W'(REQUESTERS - 1);
      else if (fifo_wr_en) last_idx <= sel;
   end

   always_comb begin
      grant = '0;
      if (fifo_wr_en) grant[sel] = 1'b1;
   end

   always_comb begin
      fifo_wr_data = '0;
      for (int i = 0; i < REQUESTERS; i++)
         if (grant[i]) fifo_wr_data = fifo_wr_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;
   localparam int N  = 4;
   localparam int DW = 22;

   logic            clk = 1'b0;
   logic            rst, ce, fifo_full, fifo_wr_en;
   logic [N-1:0]    req, grant;
   logic [N*DW-1:0] req_data;
   logic [DW-1:0]   fifo_wr_data;
   logic [1:0]      last_idx;

   fifo_write_arbiter #(.REQUESTERS(N), .DATA_WIDTH(DW), .BURST_LEN(4)) dut (
      .clk(clk), .rst(rst), .ce(ce), .req(req), .req_data(req_data),
      .grant(grant), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
      .fifo_wr_data(fifo_wr_data), .last_idx(last_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         rst, ce, full;
      logic [N-1:0] req;
      logic [N-1:0] g;     // expected grant
      int           last;  // expected last_idx, -1 = don't care
   } vec_t;

   typedef struct {
      logic [N-1:0]  g;
      logic          we;
      logic [DW-1:0] d;
      int            last;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [DW-1:0] data_for(input logic [N-1:0] g);
      data_for = '0;
      for (int i = 0; i < N; i++) if (g[i]) data_for = 22'h100 + DW'(i);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle just after the edge. The expected result goes into the
   // scoreboard and is compared at the falling edge.
   task automatic step(input logic r, input logic c, input logic f,
                       input logic [N-1:0] rq, input logic [N-1:0] g, input int last);
      exp_t e;
      @(posedge clk); #1;
      rst = r; ce = c; fifo_full = f; req = rq;
      e.g = g; e.we = (g != '0); e.d = data_for(g); e.last = last;
      q.push_back(e);
      @(negedge clk);
      e = q.pop_front();
      check("grant", 32'(grant), 32'(e.g));
      check("wr_en", 32'(fifo_wr_en), 32'(e.we));
      check("wr_data", 32'(fifo_wr_data), 32'(e.d));
      if (e.last >= 0) check("last_idx", 32'(last_idx), 32'(e.last));
   endtask

   initial begin
      vec_t v[$];
      rst = 1'b1; ce = 1'b1; fifo_full = 1'b0; req = '0;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 22'h100 + DW'(i);

`ifndef FIFO_ARB_BURST_EN
      // rst ce full req    grant    last
      v.push_back('{1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, -1}); // reset
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0001, 3});  // rotation 0..3,0
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0010, 0});
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0100, 1});
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b1111, 4'b1000, 2});
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0001, 3});
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b0101, 4'b0100, 0});  // sparse 2,0,2,0
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b0101, 4'b0001, 2});
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b0101, 4'b0100, 0});
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b0101, 4'b0001, 2});
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0010, 0});  // producer 1
      v.push_back('{1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 1});  // full stall x3
      v.push_back('{1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 1});
      v.push_back('{1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 1});
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0100, 1});  // resumes at 2
      for (int k = 0; k < 5; k++)
         v.push_back('{1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 2}); // ce low x5
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b1111, 4'b1000, 2});
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0001, 3});
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0010, 0});
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0100, 1});  // producer 2
      v.push_back('{1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, 2});  // reset mid-run
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0001, 3});  // back to 0
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b0010, 4'b0010, 0});  // single requester
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b0010, 4'b0010, 1});
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1});  // idle, no change
      v.push_back('{1'b0, 1'b1, 1'b1, 4'b1000, 4'b0000, 1});  // full blocks write
      v.push_back('{1'b0, 1'b1, 1'b0, 4'b1000, 4'b1000, 1});
      foreach (v[i]) step(v[i].rst, v[i].ce, v[i].full, v[i].req, v[i].g, v[i].last);

      // Hand sequence: without bursting, each producer gets one grant per turn.
      step(1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, -1);
      step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0001, 3);
      step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0010, 0);
      step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0100, 1);
      step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b1000, 2);
`else
      // Full bursts: 0 x4, then 1 x4, then 2.
      step(1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, -1);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0001, -1);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0010, -1);
      step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0100, 2 - 2 + 1);
      // Owner 1 drops req after two grants. The next owner is 2.
      step(1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, -1);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0001, -1);
      step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0010, 0);
      step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0010, 1);
      step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 1);   // stall holds the lock
      step(1'b0, 1'b1, 1'b0, 4'b1101, 4'b0100, 1);
      step(1'b0, 1'b1, 1'b0, 4'b1101, 4'b0100, 2);
`endif
      if (q.size() != 0) check("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
